// File: rtl/sipo_word_rx_pkg.sv
// Shared definitions for the serial word link: receiver FSM encoding and the
// default word width used by both ends of the link.
package sipo_word_rx_pkg;

  localparam int W_DEF = 8;

  typedef enum logic {
    RX_IDLE  = 1'b0,
    RX_SHIFT = 1'b1
  } rx_state_t;

endpackage

// File: rtl/word_hold_reg.sv
// One-entry valid/ready holding stage. A new word is taken when the stage is
// empty or being drained on the same edge; otherwise it is flagged as dropped.
module word_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         drop
);

  // Handshake: a word moves downstream on every rising edge where
  // out_valid and out_ready are both 1; out_data is stable while out_valid
  // is 1 and not yet accepted.
  logic take;

  assign take = in_valid && (!out_valid || out_ready);
  assign drop = in_valid && out_valid && !out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_word_rx.sv
// Serial-in/parallel-out word receiver: rebuilds LSB-first words from the
// strobed serial link and hands them to a one-entry holding stage.
module sipo_word_rx
  import sipo_word_rx_pkg::*;
#(
  parameter  int w  = W_DEF,
  localparam int CW = $clog2(w)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sh,
  input  logic          b_in,
  input  logic          clr,
  input  logic          out_ready,
  output logic [w-1:0]  data_out,
  output logic          out_valid,
  output logic          busy,
  output logic [CW-1:0] bit_cnt,
  output logic          overrun
);

  rx_state_t     state_q, state_nx;
  logic [w-1:0]  sreg_q, sreg_nx;
  logic [CW-1:0] cnt_nx;
  logic          word_done;
  logic [w-1:0]  word;
  logic          drop;

  // New bits enter at the top, so after w strobes the first bit is in bit 0.
  assign word = {b_in, sreg_q[w-1:1]};
  assign busy = (state_q == RX_SHIFT);

  always_comb begin
    state_nx  = state_q;
    sreg_nx   = sreg_q;
    cnt_nx    = bit_cnt;
    word_done = 1'b0;
    if (clr) begin
      state_nx = RX_IDLE;
      sreg_nx  = '0;
      cnt_nx   = '0;
    end else if (sh) begin
      if (bit_cnt == CW'(w - 1)) begin
        word_done = 1'b1;
        state_nx  = RX_IDLE;
        sreg_nx   = '0;
        cnt_nx    = '0;
      end else begin
        state_nx = RX_SHIFT;
        sreg_nx  = word;
        cnt_nx   = bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
      sreg_q  <= '0;
      bit_cnt <= '0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_nx;
      sreg_q  <= sreg_nx;
      bit_cnt <= cnt_nx;
      if (clr) begin
        overrun <= 1'b0;
      end else if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

  word_hold_reg #(.W(w)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (word_done),
    .in_data   (word),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (data_out),
    .drop      (drop)
  );

endmodule

// File: tb/tb_sipo_word_rx.sv
// Bench for sipo_word_rx: directed link scenarios followed by random traffic,
// checked against a bit-list reference model and an expected-word queue.
module tb_sipo_word_rx;
  localparam int W  = 8;
  localparam int CW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sh = 1'b0;
  logic          b_in = 1'b0;
  logic          clr = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  data_out;
  logic          out_valid;
  logic          busy;
  logic [CW-1:0] bit_cnt;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  // Reference model: bits received so far, and the holding stage contents.
  int           m_bits[$];
  logic [W-1:0] m_data  = '0;
  bit           m_valid = 1'b0;
  bit           m_over  = 1'b0;
  logic [W-1:0] exp_q[$];

  sipo_word_rx #(.w(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .sh        (sh),
    .b_in      (b_in),
    .clr       (clr),
    .out_ready (out_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .busy      (busy),
    .bit_cnt   (bit_cnt),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, " bit_cnt"},   32'(bit_cnt),   32'(m_bits.size()));
    chk({tag, " busy"},      32'(busy),      32'(m_bits.size() != 0));
    chk({tag, " overrun"},   32'(overrun),   32'(m_over));
    chk({tag, " out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, " data_out"},  32'(data_out),  32'(m_data));
  endtask

  // Monitor: inputs change on the falling edge, so a handshake seen just after
  // it will be taken on the next rising edge.
  always @(negedge clk) begin
    #1;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL consume: got word %0h expected no word at %0t", data_out, $time);
      end else begin
        chk("consume data_out", 32'(data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sh = 1'b0; b_in = 1'bz; clr = 1'b0; out_ready = 1'b0;
    m_bits.delete();
    m_data = '0; m_valid = 1'b0; m_over = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check_state("reset");
  endtask

  task automatic step(input logic s, input logic b, input logic c, input logic r);
    logic [W-1:0] word;
    bit           done;
    bit           consume;
    @(negedge clk);
    rst = 1'b0; sh = s; b_in = s ? b : 1'bz; clr = c; out_ready = r;
    consume = m_valid && r;
    done = 1'b0;
    word = '0;
    if (c) begin
      m_bits.delete();
      m_over = 1'b0;
    end else if (s) begin
      m_bits.push_back(int'(b));
      if (m_bits.size() == W) begin
        for (int i = 0; i < W; i++) word = word | (W'(m_bits[i]) << i);
        m_bits.delete();
        done = 1'b1;
      end
    end
    if (done) begin
      if (!m_valid || consume) begin
        m_valid = 1'b1;
        m_data  = word;
        exp_q.push_back(word);
      end else begin
        m_over = 1'b1;
      end
    end else if (consume) begin
      m_valid = 1'b0;
    end
    @(posedge clk); #1;
    check_state("step");
  endtask

  task automatic send_word(input logic [W-1:0] word, input int gap, input logic last_ready);
    for (int i = 0; i < W; i++) begin
      step(1'b1, word[i], 1'b0, (i == W - 1) ? last_ready : 1'b0);
      if (i != W - 1) repeat (gap) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [W-1:0] tx;
    do_reset();

    // Alternating bits, then a single-cycle consume.
    send_word(8'hAA, 0, 1'b0);
    chk("aa data_out", 32'(data_out), 32'h0000_00AA);
    chk("aa out_valid", 32'(out_valid), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("aa consumed", 32'(out_valid), 32'd0);
    chk("aa held", 32'(data_out), 32'h0000_00AA);

    // Loopback from an emulated right-shifting transmitter.
    tx = 8'hF0;
    for (int i = 0; i < W; i++) begin
      step(1'b1, tx[0], 1'b0, 1'b0);
      tx = tx >> 1;
    end
    chk("loopback data_out", 32'(data_out), 32'h0000_00F0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Second word completes on the edge that consumes the first.
    send_word(8'h3C, 0, 1'b0);
    send_word(8'hC3, 0, 1'b1);
    chk("b2b out_valid", 32'(out_valid), 32'd1);
    chk("b2b data_out", 32'(data_out), 32'h0000_00C3);
    chk("b2b overrun", 32'(overrun), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Overrun, then clr clears it without touching the holding stage.
    send_word(8'h11, 0, 1'b0);
    send_word(8'h22, 0, 1'b0);
    chk("ovr data_out", 32'(data_out), 32'h0000_0011);
    chk("ovr flag", 32'(overrun), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr overrun", 32'(overrun), 32'd0);
    chk("clr out_valid", 32'(out_valid), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // clr wins over a simultaneous strobe.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("clr bit_cnt", 32'(bit_cnt), 32'd0);
    chk("clr busy", 32'(busy), 32'd0);
    send_word(8'h81, 0, 1'b0);
    chk("81 data_out", 32'(data_out), 32'h0000_0081);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-word, then full words with and without strobe gaps.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    send_word(8'h5A, 0, 1'b0);
    chk("5a data_out", 32'(data_out), 32'h0000_005A);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'h5A, 3, 1'b0);
    chk("5a gap data_out", 32'(data_out), 32'h0000_005A);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step(logic'($urandom_range(0, 9) < 6), logic'($urandom_range(0, 1)),
             logic'($urandom_range(0, 29) == 0), logic'($urandom_range(0, 1)));
      end
    end

    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("final queue depth", 32'(exp_q.size()), 32'(m_valid));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
